// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction memory, sequential PC walker and QDEPTH-entry fetch FIFO.
// Optional branch-redirect flush is compiled in when FETCH_REDIRECT_EN is defined.
module inst_fetch_queue #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 7,
    parameter int QDEPTH = 4
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    input  logic [PC_W:0]           prog_len,
    input  logic                    imem_we,
    input  logic [PC_W-1:0]         imem_waddr,
    input  logic [XLEN-1:0]         imem_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_inst,
    output logic [PC_W-1:0]         out_pc,
`ifdef FETCH_REDIRECT_EN
    input  logic                    redirect_valid,
    input  logic [PC_W-1:0]         redirect_pc,
`endif
    output logic [PC_W:0]           pc,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    done
);

    localparam int AW   = $clog2(QDEPTH);
    localparam int MEMD = 1 << PC_W;
    localparam logic [AW:0]   QFULL  = QDEPTH[AW:0];
    localparam logic [PC_W:0] PC_MAX = {1'b1, {PC_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] mem_q   [MEMD];
    logic [XLEN-1:0] qinst_q [QDEPTH];
    logic [PC_W-1:0] qpc_q   [QDEPTH];

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [PC_W:0]   pc_q, pc_d;

    logic [PC_W:0]   plen;
    logic            redir;
    logic [PC_W-1:0] redir_pc;
    logic            pc_lt;
    logic            full;
    logic            pop;
    logic            push;
    logic [XLEN-1:0] fetch_word;

`ifdef FETCH_REDIRECT_EN
    assign redir    = redirect_valid;
    assign redir_pc = redirect_pc;
`else
    assign redir    = 1'b0;
    assign redir_pc = '0;
`endif

    // Lengths beyond the memory size are clamped so pc stops at 2**PC_W.
    assign plen       = (prog_len > PC_MAX) ? PC_MAX : prog_len;
    assign pc_lt      = pc_q < plen;
    assign full       = cnt_q == QFULL;
    assign out_valid  = cnt_q != '0;
    assign pop        = out_valid && out_ready && !redir;
    assign push       = !redir && (state_q == FETCH) && fetch_en
                        && pc_lt && (!full || pop);
    assign fetch_word = mem_q[pc_q[PC_W-1:0]];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redir) begin
            state_d = fetch_en ? FETCH : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) state_d = FETCH;
                end
                FETCH: begin
                    if (!fetch_en)   state_d = IDLE;
                    else if (!pc_lt) state_d = DRAIN;
                end
                DRAIN: begin
                    if (cnt_q == '0) state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        done = (state_q == DONE);
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        if (redir) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            pc_d   = {1'b0, redir_pc};
        end else begin
            if (pop) head_d = head_q + 1'b1;
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = pc_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            pc_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
        end
    end

    // Storage arrays carry no reset; a same-cycle write leaves fetch_word old.
    always_ff @(posedge clk1) begin
        if (imem_we) mem_q[imem_waddr] <= imem_wdata;
        if (push) begin
            qinst_q[tail_q] <= fetch_word;
            qpc_q[tail_q]   <= pc_q[PC_W-1:0];
        end
    end

    assign out_inst = out_valid ? qinst_q[head_q] : '0;
    assign out_pc   = out_valid ? qpc_q[head_q] : '0;
    assign pc       = pc_q;
    assign q_count  = cnt_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed test-plan steps plus random traffic,
// checked each cycle against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int XLEN   = 32;
    localparam int PC_W   = 7;
    localparam int QDEPTH = 4;
    localparam int CW     = $clog2(QDEPTH) + 1;
    localparam int MEMD   = 1 << PC_W;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic            clk1 = 1'b0;
    logic            rst_n = 1'b1;
    logic            fetch_en = 1'b0;
    logic [PC_W:0]   prog_len = '0;
    logic            imem_we = 1'b0;
    logic [PC_W-1:0] imem_waddr = '0;
    logic [XLEN-1:0] imem_wdata = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_inst;
    logic [PC_W-1:0] out_pc;
`ifdef FETCH_REDIRECT_EN
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
`endif
    logic [PC_W:0]   pc;
    logic [CW-1:0]   q_count;
    logic            done;

    inst_fetch_queue #(
        .XLEN(XLEN),
        .PC_W(PC_W),
        .QDEPTH(QDEPTH)
    ) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .prog_len(prog_len),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_pc(out_pc),
`ifdef FETCH_REDIRECT_EN
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
`endif
        .pc(pc),
        .q_count(q_count),
        .done(done)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int unsigned     pc;
        logic [XLEN-1:0] inst;
    } ent_t;

    ent_t            mq[$];
    logic [XLEN-1:0] mmem [MEMD];
    int unsigned     mpc;
    int              mst;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 0;
        mst = PH_IDLE;
    endtask

    task automatic model_step();
        int unsigned plen;
        int unsigned old_pc;
        int          old_n;
        bit          pop;
        bit          push;
        bit          rv;
        int unsigned rp;
        ent_t        e;
        plen = (int'(prog_len) > MEMD) ? MEMD : int'(prog_len);
        rv = 1'b0;
        rp = 0;
`ifdef FETCH_REDIRECT_EN
        rv = redirect_valid;
        rp = int'(redirect_pc);
`endif
        old_n  = mq.size();
        old_pc = mpc;
        if (rv) begin
            mq.delete();
            mpc = rp;
            mst = fetch_en ? PH_FETCH : PH_IDLE;
        end else begin
            pop  = (old_n != 0) && out_ready;
            push = (mst == PH_FETCH) && fetch_en && (mpc < plen)
                   && ((old_n < QDEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc   = mpc;
                e.inst = mmem[mpc];
                mq.push_back(e);
                mpc++;
            end
            case (mst)
                PH_IDLE:  if (fetch_en) mst = PH_FETCH;
                PH_FETCH: begin
                    if (!fetch_en)          mst = PH_IDLE;
                    else if (old_pc >= plen) mst = PH_DRAIN;
                end
                PH_DRAIN: if (old_n == 0) mst = PH_DONE;
                default:  mst = mst;
            endcase
        end
        if (imem_we) mmem[imem_waddr] = imem_wdata;
    endtask

    task automatic check_outputs();
        logic [XLEN-1:0] e_inst;
        int unsigned     e_pc;
        e_inst = '0;
        e_pc   = 0;
        if (mq.size() != 0) begin
            e_inst = mq[0].inst;
            e_pc   = mq[0].pc;
        end
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_inst", out_inst, e_inst);
        chk("out_pc", out_pc, e_pc);
        chk("pc", pc, mpc);
        chk("q_count", q_count, mq.size());
        chk("done", done, mst == PH_DONE);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk1);
        #1;
        check_outputs();
        @(negedge clk1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        imem_we = 1'b0;
`ifdef FETCH_REDIRECT_EN
        redirect_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_pc", pc, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_done", done, 0);
        model_reset();
        @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk1);
        do_reset();

        for (int i = 0; i < MEMD; i++) begin
            imem_we    = 1'b1;
            imem_waddr = PC_W'(i);
            imem_wdata = $urandom;
            cyc();
        end
        imem_waddr = 0; imem_wdata = 32'h0001_0183; cyc();
        imem_waddr = 1; imem_wdata = 32'h0241_1163; cyc();
        imem_waddr = 2; imem_wdata = 32'h0262_80E3; cyc();
        imem_we = 1'b0;

        // three-word program, issue always ready
        do_reset();
        prog_len = 3; fetch_en = 1'b1; out_ready = 1'b1;
        cyc();
        chk("s1_c1_valid", out_valid, 0);
        cyc();
        chk("s1_c2_pc", out_pc, 0);
        chk("s1_c2_inst", out_inst, 32'h0001_0183);
        cyc();
        chk("s1_c3_pc", out_pc, 1);
        chk("s1_c3_inst", out_inst, 32'h0241_1163);
        cyc();
        chk("s1_c4_pc", out_pc, 2);
        chk("s1_c4_inst", out_inst, 32'h0262_80E3);
        cyc();
        chk("s1_c5_valid", out_valid, 0);
        chk("s1_c5_done", done, 0);
        cyc();
        chk("s1_c6_done", done, 1);

        // saturation then simultaneous push/pop
        do_reset();
        prog_len = 7; fetch_en = 1'b1; out_ready = 1'b0;
        run(8);
        chk("s2_full_cnt", q_count, 4);
        chk("s2_full_pc", pc, 4);
        out_ready = 1'b1;
        cyc();
        chk("s2_pp_cnt", q_count, 4);
        chk("s2_pp_pc", pc, 5);
        chk("s2_pp_head", out_pc, 1);
        out_ready = 1'b0;

        // pause fetch at pc=3
        do_reset();
        prog_len = 7; fetch_en = 1'b1; out_ready = 1'b0;
        run(4);
        chk("s3_pc3", pc, 3);
        fetch_en = 1'b0; out_ready = 1'b1;
        run(3);
        chk("s3_hold_pc", pc, 3);
        chk("s3_drained", q_count, 0);
        fetch_en = 1'b1;
        run(2);
        chk("s3_resume_pc", out_pc, 3);
        chk("s3_resume_valid", out_valid, 1);

`ifdef FETCH_REDIRECT_EN
        do_reset();
        prog_len = 7; fetch_en = 1'b1; out_ready = 1'b0;
        run(4);
        chk("s4_pre_cnt", q_count, 3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5;
        cyc();
        redirect_valid = 1'b0;
        chk("s4_flush_cnt", q_count, 0);
        chk("s4_flush_valid", out_valid, 0);
        chk("s4_flush_pc", pc, 5);
        cyc();
        chk("s4_new_head", out_pc, 5);
        redirect_valid = 1'b1; redirect_pc = 9;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("s4_far_done0", done, 0);
        cyc();
        chk("s4_far_done1", done, 1);
`endif

        // same-cycle write to the word being fetched
        do_reset();
        prog_len = 7; fetch_en = 1'b1; out_ready = 1'b1;
        cyc();
        imem_we = 1'b1; imem_waddr = 0; imem_wdata = 32'hDEAD_BEEF;
        cyc();
        imem_we = 1'b0;
        chk("s5_old_word", out_inst, 32'h0001_0183);
        do_reset();
        run(2);
        chk("s5_new_word", out_inst, 32'hDEAD_BEEF);

        // asynchronous reset with two entries queued
        do_reset();
        prog_len = 7; fetch_en = 1'b1; out_ready = 1'b0;
        run(3);
        chk("s6_pre_cnt", q_count, 2);
        do_reset();
        run(2);
        chk("s6_restart_pc", out_pc, 0);
        chk("s6_restart_next", pc, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) do_reset();
            if (i % 40 == 0) prog_len = ($urandom_range(0, 255)) & 8'hFF;
            fetch_en   = $urandom_range(0, 9) < 8;
            out_ready  = $urandom_range(0, 1) == 1;
            imem_we    = $urandom_range(0, 4) == 0;
            imem_waddr = ($urandom_range(0, MEMD - 1)) & 7'h7F;
            imem_wdata = $urandom;
`ifdef FETCH_REDIRECT_EN
            redirect_valid = $urandom_range(0, 24) == 0;
            redirect_pc    = ($urandom_range(0, MEMD - 1)) & 7'h7F;
`endif
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

- Parametrised instruction-fetch front end for the Tomasulo core.
- Owns its own instruction memory (loadable through a write port), walks a program counter up to a runtime program length, and buffers fetched words in a QDEPTH-entry FIFO.
- The issue stage drains the FIFO over a valid/ready handshake; a branch-redirect path can flush the FIFO and restart at a new PC.

## Interface
- XLEN, 32, instruction word width
- PC_W, 7, program-counter width; memory holds 2**PC_W words
- QDEPTH, 4, instruction-queue depth (power of two, >= 2)

- clk1  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  allow fetching
- prog_len  in  PC_W+1  number of valid instructions, sampled every cycle
- imem_we  in  1  instruction-memory write strobe
- imem_waddr  in  PC_W  write address
- imem_wdata  in  XLEN  write data
- out_valid  out  1  queue head valid
- out_ready  in  1  issue stage accepts head
- out_inst  out  XLEN  head instruction
- out_pc  out  PC_W  PC of head instruction
- redirect_valid  in  1  flush and restart (FETCH_REDIRECT_EN only)
- redirect_pc  in  PC_W  restart PC (FETCH_REDIRECT_EN only)
- pc  out  PC_W+1  next PC to fetch
- q_count  out  $clog2(QDEPTH)+1  occupancy
- done  out  1  program fully fetched and drained

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE. Reset enters IDLE.
- IDLE -> FETCH when fetch_en=1.
- FETCH -> IDLE when fetch_en=0. PC and queue are held; the queue still drains.
- FETCH -> DRAIN when pc >= prog_len.
- DRAIN -> DONE when q_count reaches 0.
- DONE stays until reset or redirect.
- Push: in FETCH with pc < prog_len and (q_count < QDEPTH or pop this cycle).
  - mem[pc] and pc are written at the tail; pc increments by 1.
  - Full + pop in the same cycle pushes; count is unchanged.
- Pop: out_valid && out_ready; the head advances.
- out_valid = (q_count != 0). out_inst/out_pc show the head entry and must hold stable while out_valid && !out_ready.
- Memory read is asynchronous from the array. A write to the address being fetched in the same cycle yields the old word.
- pc is PC_W+1 bits, so it reaches 2**PC_W without wrapping. prog_len > 2**PC_W is clamped to 2**PC_W.
- done = 1 only in DONE.

## Timing
- Reset values:
  - out_valid=0, out_inst=0, out_pc=0, pc=0, q_count=0, done=0, state IDLE.
  - Memory contents are not reset.
- Fetch-to-issue latency: a word pushed in cycle N is visible at the head in cycle N+1 (queue empty case).
- Throughput: one instruction per cycle sustained while out_ready=1.
- Redirect (when compiled in):
  - Takes priority over push, pop, and the fetch_en transition.
  - In that cycle: queue cleared (q_count=0), no push, pop ignored, pc <= redirect_pc.
  - Next state is FETCH if fetch_en=1, else IDLE.
  - out_valid is 0 in the following cycle.
- A redirect_pc >= prog_len leads to DRAIN -> DONE on the next two edges.
- Reset asserted mid-operation clears the queue and PC immediately (asynchronous); the first push after release follows IDLE -> FETCH.
- prog_len lowered below pc during FETCH -> DRAIN on the next edge. Entries already queued remain valid.

## Configuration
- FETCH_REDIRECT_EN defined: the redirect_valid/redirect_pc ports and the flush logic exist as described.
- FETCH_REDIRECT_EN undefined:
  - Ports are absent.
  - PC is strictly sequential from 0.
  - Only reset clears the queue.
  - DONE is terminal until reset.

## Test plan
- Load words 0x00010183, 0x0241_1163, 0x0262_80E3 at 0-2; prog_len=3; fetch_en=1; out_ready=1.
  - Required: out_valid in cycles 2-4 with out_pc 0, 1, 2 and matching words.
  - Required: done=1 two cycles after the last pop.
- QDEPTH=4, prog_len=7, out_ready=0.
  - Required: q_count saturates at 4 and pc holds at 4.
  - Then raise out_ready for 1 cycle: a push and a pop occur together and q_count stays 4.
- Mid-stream fetch_en=0 at pc=3.
  - Required: pc holds at 3 and the queue drains to 0.
  - Re-enabling resumes with out_pc=3.
- Redirect to 5 with 3 entries queued and out_ready=1.
  - Required: q_count=0 next cycle and no pop of the old head.
  - Required: next out_pc=5.
  - Redirect to 9 with prog_len=7: done=1 after 2 cycles.
- Same-cycle imem write of 0xDEADBEEF to the address being fetched.
  - Required: the queued word is the old value; a later fetch of that address returns 0xDEADBEEF.
- rst_n low for 1 cycle mid-FETCH with q_count=2.
  - Required: all outputs 0 asynchronously.
  - Required: after release, fetch restarts at pc=0.
